// File: rtl/four_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   N_REQ          : number of requesters
//   state_t        : arbiter state encoding (IDLE / GRANT)
//   onehot_to_idx  : converts a one-hot grant vector to its index
package four_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Assumes oh is one-hot; an all-zero vector maps to index 0.
  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/four_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req     : request lines, bit i = requester i
//   done    : current holder releases the grant
//   gnt     : one-hot grant or all-zero (feeds the four_two encoder p,q,r,s)
//   busy    : high while any grant is active
//   timeout : one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface four_rr_arbiter_if;
  import four_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output busy,
    output timeout
  );

endinterface

// File: rtl/four_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick among four requesters.
//   req    : request lines
//   ptr    : index of the highest-priority requester
//   onehot : selected requester, one-hot, or zero when no request
//   any    : at least one request present
// Rotates req so ptr lands on bit 0, takes the lowest set bit, rotates back.
module rr_pick4
  import four_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);

  logic [N_REQ-1:0] req_rot;
  logic [N_REQ-1:0] pick_rot;
  logic             found;
  logic [1:0]       idx;

  always_comb begin
    req_rot  = '0;
    pick_rot = '0;
    onehot   = '0;
    found    = 1'b0;
    idx      = 2'd0;

    for (int i = 0; i < N_REQ; i++) begin
      idx        = 2'(i) + ptr;
      req_rot[i] = req[idx];
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (req_rot[i] && !found) begin
        pick_rot[i] = 1'b1;
        found       = 1'b1;
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      idx         = 2'(i) + ptr;
      onehot[idx] = pick_rot[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/four_rr_arbiter.sv
// Four-requester round-robin arbiter with hold timeout.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : four_rr_arbiter_if.slave (req, done in; gnt, busy, timeout out)
// Parameters:
//   MAX_HOLD : max grant length in cycles before forced release; 0 disables
//   CW       : hold-counter width, 2^CW must exceed MAX_HOLD
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no grant; pick next requester from ptr, one-cycle gap
// ST_GRANT | one requester holds gnt until done, request drop or timeout
module four_rr_arbiter
  import four_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input logic             clk,
  input logic             rst,
  four_rr_arbiter_if.slave bus
);

  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] pick;
  logic             any_req;
  logic [1:0]       g_idx;

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick),
    .any    (any_req)
  );

  assign g_idx = onehot_to_idx(gnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (any_req) begin
          gnt_d   = pick;
          state_d = ST_GRANT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_GRANT: begin
        // done has priority over the timeout; only req[g] is looked at here.
        if (bus.done || !bus.req[g_idx]) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          ptr_d   = g_idx + 2'd1;
          cnt_d   = '0;
        end else if (TIMEOUT_EN && (cnt_q == HOLD_LIMIT)) begin
          gnt_d     = '0;
          state_d   = ST_IDLE;
          ptr_d     = g_idx + 2'd1;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (TIMEOUT_EN && (cnt_q < HOLD_LIMIT)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // With the timeout disabled cnt simply stays at 1.
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_four_rr_arbiter.sv
module tb_four_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  int n_cmp;
  int n_err;
  bit inv_on;

  four_rr_arbiter_if bus0 ();
  four_rr_arbiter_if bus1 ();

  assign bus0.req  = req;
  assign bus0.done = done;
  assign bus1.req  = req;
  assign bus1.done = done;

  four_rr_arbiter #(.MAX_HOLD(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  // Timeout disabled: must never pulse timeout and must hold past 8 cycles.
  four_rr_arbiter #(.MAX_HOLD(0), .CW(4)) dut_nt (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream four_two encoder: p,q,r,s -> ab
  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_onehot0", {3'b0, $onehot0(bus0.gnt)}, 4'd1);
      chk("inv_busy0", {3'b0, bus0.busy}, {3'b0, |bus0.gnt});
      chk("inv_onehot1", {3'b0, $onehot0(bus1.gnt)}, 4'd1);
      chk("inv_busy1", {3'b0, bus1.busy}, {3'b0, |bus1.gnt});
    end
  end

  logic [3:0] seq_gnt [9];
  logic [1:0] seq_ab  [9];

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    inv_on = 1'b0;
    rst    = 1'b1;
    req    = 4'b0000;
    done   = 1'b0;

    // Reset state
    tick();
    inv_on = 1'b1;
    chk("rst_gnt", bus0.gnt, 4'b0000);
    chk("rst_busy", {3'b0, bus0.busy}, 4'd0);
    chk("rst_timeout", {3'b0, bus0.timeout}, 4'd0);
    rst = 1'b0;
    tick();
    chk("idle_noreq", bus0.gnt, 4'b0000);

    // Single requester, done on 3rd grant cycle
    req = 4'b0001;
    tick();
    chk("t1_c1", bus0.gnt, 4'b0001);
    chk("t1_busy", {3'b0, bus0.busy}, 4'd1);
    chk("t1_ab", {2'b0, enc(bus0.gnt)}, 4'd0);
    tick();
    chk("t1_c2", bus0.gnt, 4'b0001);
    tick();
    chk("t1_c3", bus0.gnt, 4'b0001);
    done = 1'b1;
    tick();
    chk("t1_c4", bus0.gnt, 4'b0000);
    chk("t1_c4_to", {3'b0, bus0.timeout}, 4'd0);
    done = 1'b0;
    req  = 4'b0011;  // ptr is now 1, so requester 1 wins
    tick();
    chk("t1_ptr1", bus0.gnt, 4'b0010);
    req = 4'b0000;
    tick();
    chk("t1_drop", bus0.gnt, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // All requesting, done every grant cycle
    seq_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    seq_ab  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t2_gnt%0d", i), bus0.gnt, seq_gnt[i]);
      if (seq_gnt[i] != 4'b0000)
        chk($sformatf("t2_ab%0d", i), {2'b0, enc(bus0.gnt)}, {2'b0, seq_ab[i]});
      chk($sformatf("t2_to%0d", i), {3'b0, bus0.timeout}, 4'd0);
    end
    req  = 4'b0000;
    done = 1'b0;
    tick();
    chk("t2_end", bus0.gnt, 4'b0000);

    // Timeout after exactly 8 cycles, re-grant after one idle cycle
    req = 4'b0100;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t3_hold%0d", i), bus0.gnt, 4'b0100);
      chk($sformatf("t3_to%0d", i), {3'b0, bus0.timeout}, 4'd0);
    end
    tick();
    chk("t3_rel", bus0.gnt, 4'b0000);
    chk("t3_to_pulse", {3'b0, bus0.timeout}, 4'd1);
    chk("t3_busy", {3'b0, bus0.busy}, 4'd0);
    chk("nt_hold9", bus1.gnt, 4'b0100);
    chk("nt_to9", {3'b0, bus1.timeout}, 4'd0);
    tick();
    chk("t3_regrant", bus0.gnt, 4'b0100);
    chk("t3_to_off", {3'b0, bus0.timeout}, 4'd0);
    chk("nt_hold10", bus1.gnt, 4'b0100);
    chk("nt_to10", {3'b0, bus1.timeout}, 4'd0);

    // done on the same edge the hold limit is reached
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("t4_hold%0d", i), bus0.gnt, 4'b0100);
    end
    done = 1'b1;
    tick();
    chk("t4_rel", bus0.gnt, 4'b0000);
    chk("t4_no_to", {3'b0, bus0.timeout}, 4'd0);
    chk("nt_rel", bus1.gnt, 4'b0000);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    chk("t4_idle", bus0.gnt, 4'b0000);

    // Holder drops while another requester toggles (ptr is 3 here)
    req = 4'b0010;
    tick();
    chk("t5_g1", bus0.gnt, 4'b0010);
    req = 4'b1010;
    tick();
    chk("t5_tog_a", bus0.gnt, 4'b0010);
    req = 4'b0010;
    tick();
    chk("t5_tog_b", bus0.gnt, 4'b0010);
    req = 4'b1010;
    tick();
    chk("t5_tog_c", bus0.gnt, 4'b0010);
    req = 4'b1000;
    tick();
    chk("t5_drop", bus0.gnt, 4'b0000);
    chk("t5_no_to", {3'b0, bus0.timeout}, 4'd0);
    tick();
    chk("t5_g3", bus0.gnt, 4'b1000);
    chk("t5_ab", {2'b0, enc(bus0.gnt)}, 4'd3);
    done = 1'b1;
    tick();
    chk("t5_rel", bus0.gnt, 4'b0000);
    done = 1'b0;
    req  = 4'b0000;
    tick();

    // Reset mid-grant, then ptr back at 0
    req = 4'b0100;
    tick();
    chk("t6_g2", bus0.gnt, 4'b0100);
    tick();
    chk("t6_g2_hold", bus0.gnt, 4'b0100);
    rst = 1'b1;
    tick();
    chk("t6_rst_gnt", bus0.gnt, 4'b0000);
    chk("t6_rst_busy", {3'b0, bus0.busy}, 4'd0);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    chk("t6_ptr0", bus0.gnt, 4'b0001);
    chk("t6_nt_ptr0", bus1.gnt, 4'b0001);

    inv_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
